// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared state encoding and reference pattern for moore_seq_detector
// Contents: state_t (3-bit binary FSM encoding 0..4), PATTERN (bit stream that raises z, oldest bit at MSB)
package moore_seq_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1010 = 3'd4
    } state_t;
    localparam logic [3:0] PATTERN = 4'b1010;
endpackage

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore FSM that flags the serial pattern 1-0-1-0 on x
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   x         serial data bit, sampled on each rising clk edge
//   z         detect flag, high while the FSM sits in S1010
//   det_count saturating detection counter (present only with SEQ_DET_COUNT_EN)
// Parameters: OVERLAP (1 = trailing "10" seeds the next match), CNT_W (counter width)
// Optional feature: define SEQ_DET_COUNT_EN to add det_count
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
`ifdef SEQ_DET_COUNT_EN
    output logic [CNT_W-1:0] det_count,
`endif
    output logic             z
);
    state_t r_state;
    state_t w_next;
    logic   r_z;
    // Unused encodings fall back to IDLE on the next edge.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = x ? S1 : IDLE;
            S1:      w_next = x ? S1 : S10;
            S10:     w_next = x ? S101 : IDLE;
            S101:    w_next = x ? S1 : S1010;
            S1010:   w_next = x ? ((OVERLAP != 0) ? S101 : S1) : IDLE;
            default: w_next = IDLE;
        endcase
    end
    // z is registered from the next state so it equals (r_state == S1010).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_z     <= (w_next == S1010);
        end
    end
    assign z = r_z;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_next == S1010 && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
    end
    assign det_count = r_cnt;
`endif
endmodule

// File: tb/tb_moore_seq_detector.sv
// tb_moore_seq_detector: scoreboard bench for moore_seq_detector (overlap and non-overlap instances)
module tb_moore_seq_detector;
    import moore_seq_pkg::*;
    localparam int CW = 2;

    typedef struct {
        bit z_ov;
        bit z_no;
        int c_ov;
        int c_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic x = 1'b0;
    logic z_ov, z_no;
`ifdef SEQ_DET_COUNT_EN
    logic [CW-1:0] dc_ov, dc_no;
`endif

    moore_seq_detector #(.OVERLAP(1), .CNT_W(CW)) u_ov (
        .clk(clk), .rst_n(rst_n), .x(x),
`ifdef SEQ_DET_COUNT_EN
        .det_count(dc_ov),
`endif
        .z(z_ov));
    moore_seq_detector #(.OVERLAP(0), .CNT_W(CW)) u_no (
        .clk(clk), .rst_n(rst_n), .x(x),
`ifdef SEQ_DET_COUNT_EN
        .det_count(dc_no),
`endif
        .z(z_no));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    exp_t sb[$];

    // Reference model: bits received since reset (overlap) or since reset/last match (no overlap);
    // a detection is simply "the last four bits read PATTERN".
    bit h_ov[$];
    bit h_no[$];
    int m_cov = 0;
    int m_cno = 0;
    localparam int CMAX = (1 << CW) - 1;

    task automatic check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit tail_match(bit h[$]);
        logic [3:0] w;
        if (h.size() < 4) return 1'b0;
        w = {h[h.size()-4], h[h.size()-3], h[h.size()-2], h[h.size()-1]};
        return w == PATTERN;
    endfunction

    function automatic void model_clear();
        h_ov.delete();
        h_no.delete();
        m_cov = 0;
        m_cno = 0;
    endfunction

    // Drive one bit for the coming edge and queue the response expected after it.
    task automatic drive(bit b, bit r = 1'b1);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        x = b;
        if (!r) begin
            model_clear();
            e = '{0, 0, 0, 0};
        end else begin
            h_ov.push_back(b);
            h_no.push_back(b);
            e.z_ov = tail_match(h_ov);
            e.z_no = tail_match(h_no);
            if (e.z_no) h_no.delete();
            if (h_ov.size() > 4) void'(h_ov.pop_front());
            if (h_no.size() > 4) void'(h_no.pop_front());
            if (e.z_ov && m_cov < CMAX) m_cov++;
            if (e.z_no && m_cno < CMAX) m_cno++;
            e.c_ov = m_cov;
            e.c_no = m_cno;
        end
        sb.push_back(e);
    endtask

    task automatic drive_seq(logic [15:0] bits, int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) drive(v[i]);
    endtask

    // Monitor: sample one cycle's outputs just after each edge and compare with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("z_overlap", int'(z_ov), int'(e.z_ov));
                check("z_no_overlap", int'(z_no), int'(e.z_no));
`ifdef SEQ_DET_COUNT_EN
                check("count_overlap", int'(dc_ov), e.c_ov);
                check("count_no_overlap", int'(dc_no), e.c_no);
`endif
            end
        end
    end

    initial begin
        #1;
        check("reset_z_ov_async", int'(z_ov), 0);
        check("reset_z_no_async", int'(z_no), 0);
        for (int i = 0; i < 3; i++) drive(i[0], 1'b0);
        drive(1'b1);
        drive_seq(16'b010, 3);
        drive_seq(16'b0, 2);
        drive_seq(16'b11010101010, 11);
        drive_seq(16'b00, 2);
        drive_seq(16'b1001011011, 10);
        for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)));
        drive_seq(16'b1010, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_z_ov_async", int'(z_ov), 0);
        check("midreset_z_no_async", int'(z_no), 0);
`ifdef SEQ_DET_COUNT_EN
        check("midreset_count_async", int'(dc_ov), 0);
`endif
        drive(1'b1, 1'b0);
        drive_seq(16'b1010101010, 10);
        for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)));
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Moore-type serial sequence detector: samples one bit `x` per clock and asserts `z` after the pattern 1-0-1-0 has been received.
- Overlapping matches are supported by default.
- Output `z` is a pure function of the registered state, never of `x` combinationally.
- Used as a leaf block in serial-stream monitoring logic.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (the trailing "10" of a match seeds the next match); 0 = after a match, restart from scratch.
- CNT_W, 8, width of the detection counter; used only when SEQ_DET_COUNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- x  input  1  serial data bit, sampled on each rising clk edge
- z  output  1  detect flag; high for every cycle the FSM is in state S1010
- det_count  output  CNT_W  number of detections; present only with SEQ_DET_COUNT_EN

Behaviour:
- Reset: rst_n=0 asynchronously forces state IDLE, so z=0 (and det_count=0) immediately, independent of clk.
- Reset deassertion is sampled at the next rising edge.
- FSM has 5 states, one state register, and updates on posedge clk only.
- Transitions (x=0 / x=1):
  - IDLE: IDLE / S1
  - S1: S10 / S1
  - S10: IDLE / S101
  - S101: S1010 / S1
  - S1010 with OVERLAP=1: IDLE / S101
  - S1010 with OVERLAP=0: IDLE / S1
- Output decode: z = (state == S1010). No other state drives z.
- Latency: the edge that samples the final 0 of the pattern moves the FSM to S1010. z rises just after that edge and stays high for exactly one cycle unless the next bits re-enter S1010.
- Back-to-back overlapping matches: with stream 1010 then 10, z pulses on the 4th and 6th bits.
- x is sampled only at rising edges; x changes between edges have no effect.
- X/illegal state: any unused encoding returns to IDLE on the next edge; z=0 in that state.
- Reset mid-pattern discards partial progress; detection restarts from IDLE.

Optional Feature:
- Macro SEQ_DET_COUNT_EN.
- Defined:
  - adds output det_count[CNT_W-1:0];
  - increments by 1 on every clock edge where next_state == S1010;
  - saturates at all-ones and does not wrap;
  - cleared to 0 by rst_n.
- Undefined: port and counter logic are absent; z behaviour is identical either way.

Decomposition:
- Package moore_seq_pkg holds:
  - typedef enum state_t {IDLE, S1, S10, S101, S1010} with 3-bit binary encoding 0..4;
  - constant PATTERN = 4'b1010 for bench reference-model use.
- Single module with no sub-modules.
- The optional counter is a small always block inside moore_seq_detector.

Test Plan:
- Reset: hold rst_n=0 with x toggling for 3 cycles -> z=0 throughout. Assert rst_n low between edges -> z=0 immediately, without waiting for an edge.
- Basic detect: x = 1,0,1,0 on 4 consecutive edges -> z=1 for exactly the cycle after the 4th edge, then 0 when the next x=1.
- Overlap (OVERLAP=1): x = 1,1,0,1,0,1,0,1,0,1,0 -> z pulses after bits 5, 7, 9 and 11 (4 pulses), with z=0 on intervening cycles.
- No overlap (OVERLAP=0): same stream -> z pulses after bits 5 and 9 only.
- Near misses: x = 1,0,0,1,0,1,1,0,1,1 -> z never asserts.
- Counter (SEQ_DET_COUNT_EN, CNT_W=2): 5 overlapping matches -> det_count goes 1,2,3,3,3 and saturates. Reset mid-stream -> det_count=0.
